// File: rtl/mux_nx1_arb.sv
// Registered N:1 channel multiplexer with valid/ready handshakes on every input and on the output.
// Selection is either a fixed index (SEL) or round-robin arbitration starting at a rotating pointer.
module mux_nx1_arb #(
  parameter  int P_N   = 4,
  parameter  int P_W   = 4,
  localparam int P_SEL = (P_N > 1) ? $clog2(P_N) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               MODO,
  input  logic [P_SEL-1:0]   SEL,
  input  logic [P_N*P_W-1:0] ENT,
  input  logic [P_N-1:0]     ENT_VALID,
  output logic [P_N-1:0]     ent_ready,
  output logic [P_W-1:0]     saida,
  output logic [P_SEL-1:0]   saida_canal,
  output logic               saida_valid,
  input  logic               SAIDA_READY
);

  function automatic logic [P_SEL-1:0] wrap_inc(input logic [P_SEL-1:0] idx);
    if (int'(idx) == P_N - 1) return '0;
    return idx + P_SEL'(1);
  endfunction

  logic               load_p0;
  logic               gnt_vld_p0;
  logic [P_SEL-1:0]   gnt_p0;
  logic [P_W-1:0]     gnt_data_p0;
  logic               xfer_p0;
  logic [P_SEL-1:0]   ptr_p1;
  logic [P_W-1:0]     data_p1;
  logic [P_SEL-1:0]   canal_p1;
  logic               vld_p1;

  // Stage p0: grant selection and input handshake (combinational)
  assign load_p0 = !vld_p1 || SAIDA_READY;

  always_comb begin
    int idx;
    gnt_vld_p0 = 1'b0;
    gnt_p0     = '0;
    idx        = 0;
    if (!MODO) begin
      // An out-of-range SEL simply matches no channel.
      for (int i = 0; i < P_N; i++) begin
        if (SEL == P_SEL'(i) && ENT_VALID[i]) begin
          gnt_vld_p0 = 1'b1;
          gnt_p0     = P_SEL'(i);
        end
      end
    end else begin
      // Walk offsets from farthest to nearest so the channel closest to ptr wins.
      for (int k = P_N - 1; k >= 0; k--) begin
        idx = int'(ptr_p1) + k;
        if (idx >= P_N) idx = idx - P_N;
        if (ENT_VALID[idx]) begin
          gnt_vld_p0 = 1'b1;
          gnt_p0     = P_SEL'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt_data_p0 = '0;
    for (int i = 0; i < P_N; i++) begin
      if (gnt_p0 == P_SEL'(i)) gnt_data_p0 = ENT[i*P_W +: P_W];
    end
  end

  assign xfer_p0 = !RST && load_p0 && gnt_vld_p0;

  always_comb begin
    ent_ready = '0;
    for (int i = 0; i < P_N; i++) begin
      if (xfer_p0 && gnt_p0 == P_SEL'(i)) ent_ready[i] = 1'b1;
    end
  end

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1 <= 1'b0;
      ptr_p1 <= '0;
    end else begin
      if (load_p0) vld_p1 <= gnt_vld_p0;
      if (xfer_p0 && MODO) ptr_p1 <= wrap_inc(gnt_p0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_p1  <= '0;
      canal_p1 <= '0;
    end else if (xfer_p0) begin
      data_p1  <= gnt_data_p0;
      canal_p1 <= gnt_p0;
    end
  end

  assign saida       = data_p1;
  assign saida_canal = canal_p1;
  assign saida_valid = vld_p1;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Bench for mux_nx1_arb: a 4-channel and a 3-channel instance share control inputs and are
// compared cycle by cycle against an arithmetic reference model plus an in-order word scoreboard.
module tb_mux_nx1_arb;

  logic        CLK = 1'b0;
  logic        RST, MODO, SAIDA_READY;
  logic [1:0]  SEL;
  logic [15:0] ENT;
  logic [3:0]  ENT_VALID;

  logic [3:0]  rdy4, out4;
  logic [1:0]  can4;
  logic        vld4;
  logic [2:0]  rdy3;
  logic [3:0]  out3;
  logic [1:0]  can3;
  logic        vld3;

  always #5 CLK = ~CLK;

  mux_nx1_arb #(.P_N(4), .P_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .MODO(MODO), .SEL(SEL), .ENT(ENT), .ENT_VALID(ENT_VALID),
    .ent_ready(rdy4), .saida(out4), .saida_canal(can4), .saida_valid(vld4),
    .SAIDA_READY(SAIDA_READY)
  );

  mux_nx1_arb #(.P_N(3), .P_W(4)) dut3 (
    .CLK(CLK), .RST(RST), .MODO(MODO), .SEL(SEL), .ENT(ENT[11:0]), .ENT_VALID(ENT_VALID[2:0]),
    .ent_ready(rdy3), .saida(out3), .saida_canal(can3), .saida_valid(vld3),
    .SAIDA_READY(SAIDA_READY)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state, index 0 = 4-channel instance, 1 = 3-channel instance
  bit m_known = 1'b0;
  bit m_vld [2];
  int m_dat [2];
  int m_can [2];
  int m_ptr [2];
  int sb0 [$];
  int sb1 [$];

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int ref_grant(input int d);
    int n;
    int idx;
    n = nch(d);
    if (!MODO) begin
      if (int'(SEL) < n && ENT_VALID[SEL]) return int'(SEL);
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      idx = (m_ptr[d] + k) % n;
      if (ENT_VALID[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step();
    int g, exp_rdy, got_rdy, got_vld, got_dat, got_can, front, n;
    bit load;
    #1;
    for (int d = 0; d < 2; d++) begin
      g        = ref_grant(d);
      load     = !m_vld[d] || SAIDA_READY;
      exp_rdy  = (!RST && load && g >= 0) ? (1 << g) : 0;
      got_rdy  = (d == 0) ? int'(rdy4) : int'(rdy3);
      got_vld  = (d == 0) ? int'(vld4) : int'(vld3);
      got_dat  = (d == 0) ? int'(out4) : int'(out3);
      got_can  = (d == 0) ? int'(can4) : int'(can3);
      if (m_known || RST) chk($sformatf("ready_n%0d", nch(d)), got_rdy, exp_rdy);
      if (m_known) begin
        chk($sformatf("valid_n%0d", nch(d)), got_vld, int'(m_vld[d]));
        if (m_vld[d]) begin
          chk($sformatf("saida_n%0d", nch(d)), got_dat, m_dat[d]);
          chk($sformatf("canal_n%0d", nch(d)), got_can, m_can[d]);
        end
        if (!RST && m_vld[d] && SAIDA_READY) begin
          if (d == 0) begin
            if (sb0.size() == 0) chk("order_empty_n4", 0, 1);
            else begin front = sb0.pop_front(); chk("order_n4", got_can * 16 + got_dat, front); end
          end else begin
            if (sb1.size() == 0) chk("order_empty_n3", 0, 1);
            else begin front = sb1.pop_front(); chk("order_n3", got_can * 16 + got_dat, front); end
          end
        end
      end
    end
    @(posedge CLK);
    for (int d = 0; d < 2; d++) begin
      n    = nch(d);
      g    = ref_grant(d);
      load = !m_vld[d] || SAIDA_READY;
      if (RST) begin
        m_vld[d] = 1'b0; m_dat[d] = 0; m_can[d] = 0; m_ptr[d] = 0;
        if (d == 0) sb0.delete(); else sb1.delete();
      end else if (load) begin
        if (g >= 0) begin
          m_vld[d] = 1'b1;
          m_dat[d] = int'(ENT[g*4 +: 4]);
          m_can[d] = g;
          if (MODO) m_ptr[d] = (g + 1) % n;
          if (d == 0) sb0.push_back(g * 16 + m_dat[d]);
          else        sb1.push_back(g * 16 + m_dat[d]);
        end else begin
          m_vld[d] = 1'b0;
        end
      end
    end
    if (RST) m_known = 1'b1;
    #1;
  endtask

  initial begin
    int exp_skip [4];
    int held, held_can;
    exp_skip = '{1, 3, 1, 3};

    RST = 1'b1; MODO = 1'b1; SEL = 2'd0; SAIDA_READY = 1'b1;
    ENT = 16'h4321; ENT_VALID = 4'hF;
    step(); step();
    chk("rst_valid", int'(vld4), 0);
    chk("rst_saida", int'(out4), 0);
    chk("rst_canal", int'(can4), 0);
    chk("rst_ready", int'(rdy4), 0);

    RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_canal", int'(can4), k % 4);
      chk("rr_saida", int'(out4), (k % 4) + 1);
    end

    RST = 1'b1; step(); RST = 1'b0;
    ENT_VALID = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("skip_canal", int'(can4), exp_skip[k]);
    end
    ENT_VALID = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("skip_drop_canal", int'(can4), 1);
    end

    MODO = 1'b0; SEL = 2'd2; ENT = 16'h4A21; ENT_VALID = 4'hF;
    #1 chk("fix_ready", int'(rdy4), 4);
    step();
    chk("fix_saida", int'(out4), 10);
    chk("fix_canal", int'(can4), 2);
    chk("fix_saida_n3", int'(out3), 10);
    step();
    chk("fix_stream_valid", int'(vld4), 1);
    SEL = 2'd3;
    #1 chk("sel_oob_ready_n3", int'(rdy3), 0);
    step();
    chk("sel_oob_valid_n3", int'(vld3), 0);
    chk("sel3_canal_n4", int'(can4), 3);

    MODO = 1'b1; SEL = 2'd0; ENT_VALID = 4'hF; SAIDA_READY = 1'b1;
    step();
    SAIDA_READY = 1'b0;
    held = int'(out4); held_can = int'(can4);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_ready", int'(rdy4), 0);
      chk("bp_saida", int'(out4), held);
      chk("bp_canal", int'(can4), held_can);
    end
    SAIDA_READY = 1'b1;
    step();
    chk("bp_next_canal", int'(can4), (held_can + 1) % 4);
    chk("bp_next_valid", int'(vld4), 1);

    RST = 1'b1; step(); RST = 1'b0;
    step(); step();
    chk("mid_pre_canal", int'(can4), 1);
    SAIDA_READY = 1'b0; RST = 1'b1;
    step();
    chk("mid_valid", int'(vld4), 0);
    RST = 1'b0; SAIDA_READY = 1'b1;
    step();
    chk("mid_ptr_canal", int'(can4), 0);

    for (int c = 0; c < 400; c++) begin
      RST         = ($urandom_range(0, 49) == 0);
      MODO        = $urandom_range(0, 1) == 1;
      SEL         = 2'($urandom_range(0, 3));
      ENT         = 16'($urandom);
      ENT_VALID   = 4'($urandom_range(0, 15));
      SAIDA_READY = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/mux_nx1_arb.md
Name: mux_nx1_arb

Overview:
- Parametrised, registered successor to the combinational 4:1 4-bit mux.
- Selects one of P_N input channels of P_W bits and registers the chosen word with a valid/ready handshake on every input channel and on the output.
- Two selection modes: fixed (external SEL) and round-robin arbitration.
- Used wherever several producers share one downstream consumer.

Parameters:
- P_N, 4, number of input channels (≥2, need not be a power of two).
- P_W, 4, data width per channel.
- P_SEL, $clog2(P_N), SEL and channel-id width; derived, not overridden.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  reset; synchronous, active-high.
- MODO  input  1  0 = fixed select by SEL, 1 = round-robin.
- SEL  input  P_SEL  channel index used in fixed mode.
- ENT  input  P_N*P_W  flattened channel data; channel i occupies bits [i*P_W +: P_W].
- ENT_VALID  input  P_N  per-channel valid.
- ent_ready  output  P_N  per-channel ready (combinational).
- saida  output  P_W  registered output data.
- saida_canal  output  P_SEL  index of the channel that produced saida.
- saida_valid  output  1  output register holds valid data.
- SAIDA_READY  input  1  consumer accepts saida this cycle.

Behaviour:
- Reset (synchronous, priority over everything):
  - saida=0, saida_canal=0, saida_valid=0.
  - Round-robin pointer ptr=0.
  - ent_ready=0 while RST=1.
- Transfers:
  - Input transfer on channel i: ENT_VALID[i] & ent_ready[i] at the clock edge.
  - Output transfer: saida_valid & SAIDA_READY.
- load = !saida_valid | SAIDA_READY. The output register can accept a new word this cycle.
- Grant, combinational, at most one channel:
  - Fixed mode: grant = SEL, only if SEL < P_N and ENT_VALID[SEL]; otherwise no grant. SEL ≥ P_N never grants, never raises ent_ready, and produces no error.
  - Round-robin mode: grant = first i with ENT_VALID[i], searching ptr, ptr+1, …, P_N-1, 0, …, ptr-1. No valid channel means no grant.
- ent_ready[i] = load & (grant exists) & (grant == i). All other bits are 0. ent_ready may depend on ENT_VALID; producers must not make ENT_VALID depend on ent_ready.
- Clock edge, when load = 1:
  - With a grant: saida <= ENT[grant], saida_canal <= grant, saida_valid <= 1.
  - Without a grant: saida_valid <= 0; saida and saida_canal hold.
- Clock edge, when load = 0 (stall): all output registers hold, and ent_ready = 0 for every channel.
- Latency and throughput: 1 cycle from input transfer to saida_valid. One word per cycle sustained when SAIDA_READY stays 1.
- Pointer:
  - On an input transfer in round-robin mode: ptr <= (grant == P_N-1) ? 0 : grant+1.
  - In fixed mode ptr holds.
  - Without a transfer ptr holds.
- Simultaneous output transfer and new grant in the same cycle: the new word replaces the old one with no bubble, and saida_valid stays 1.
- MODO or SEL change: takes effect in the same cycle's grant. A word already in the output register is unaffected. ptr is retained across mode switches.
- Data stability: the block never drops or duplicates a word. Each input transfer produces exactly one output transfer, in acceptance order.
- Reset mid-operation: a word held in the output register is discarded (saida_valid=0 next cycle), and ptr returns to 0.

Test Plan:
- Reset → RST=1 for 2 cycles with all ENT_VALID=1 → saida=0, saida_valid=0, saida_canal=0, ent_ready=0; after release the first grant in round-robin mode is channel 0.
- Fixed mode →
  - MODO=0, SEL=2, ENT ch2=4'hA, all valid, SAIDA_READY=1 → ent_ready=4'b0100, saida=4'hA and saida_canal=2 one cycle later, one word per cycle.
  - Repeat with P_N=3 and SEL=3 → ent_ready=0, saida_valid falls to 0.
- Round-robin fairness → MODO=1, all four channels valid (data 1,2,3,4), SAIDA_READY=1 → saida_canal sequence 0,1,2,3,0,… and saida 1,2,3,4,1.
- Round-robin skip → valid=4'b1010, ptr=0 → grants 1,3,1,3; then drop ch3 valid → grants 1,1.
- Backpressure → saida_valid=1 and SAIDA_READY=0 for 3 cycles → ent_ready=0, saida and saida_canal stable, ptr frozen; release → held word transfers and the next word loads in the same cycle.
- Reset mid-stream → RST=1 while saida_valid=1 and ptr=2 → next cycle saida_valid=0 and ptr=0; the held word is never transferred.
